// File: rtl/punch_encode1_pkg.sv
// rtl/punch_encode1_pkg.sv - shared card constants, EBCDIC codes and FSM states
package punch_encode1_pkg;

    localparam int ROW12 = 11;
    localparam int ROW11 = 10;
    localparam int ROW0  = 9;
    localparam int ROW1  = 8;
    localparam int ROW2  = 7;
    localparam int ROW3  = 6;
    localparam int ROW4  = 5;
    localparam int ROW5  = 4;
    localparam int ROW6  = 3;
    localparam int ROW7  = 2;
    localparam int ROW8  = 1;
    localparam int ROW9  = 0;

    localparam logic [7:0] E_SP     = 8'h40;
    localparam logic [7:0] E_0      = 8'hF0;
    localparam logic [7:0] E_A      = 8'hC1;
    localparam logic [7:0] E_J      = 8'hD1;
    localparam logic [7:0] E_S      = 8'hE2;
    localparam logic [7:0] E_PERIOD = 8'h4B;
    localparam logic [7:0] E_COMMA  = 8'h6B;
    localparam logic [7:0] E_MINUS  = 8'h60;
    localparam logic [7:0] E_SLASH  = 8'h61;
    localparam logic [7:0] E_AMP    = 8'h50;

    localparam logic [11:0] HOLL_BLANK = 12'h000;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_PAD = 1'b1
    } state_e;

    // Digit rows 0..9 sit at consecutive bits counting down from row 0.
    function automatic logic [11:0] row_n(input logic [3:0] n);
        return 12'(1) << (4'(ROW0) - n);
    endfunction

endpackage

// File: rtl/punch_encode1_if.sv
// rtl/punch_encode1_if.sv - byte-in / column-out stream bundle
interface punch_encode1_if #(
    parameter int CW = 8
);
    logic          i_valid;
    logic [7:0]    i_byte;
    logic          o_ready;
    logic          i_flush;
    logic          o_col_valid;
    logic [11:0]   o_col;
    logic          i_col_ready;
    logic          o_last;
    logic          o_err;
    logic [CW-1:0] o_colno;

    modport slave (
        input  i_valid, i_byte, i_flush, i_col_ready,
        output o_ready, o_col_valid, o_col, o_last, o_err, o_colno
    );

    modport master (
        output i_valid, i_byte, i_flush, i_col_ready,
        input  o_ready, o_col_valid, o_col, o_last, o_err, o_colno
    );
endinterface

// File: rtl/punch_encode1_ebcdic_to_holl.sv
// rtl/punch_encode1_ebcdic_to_holl.sv - combinational EBCDIC to Hollerith column encoder
module punch_encode1_ebcdic_to_holl
    import punch_encode1_pkg::*;
(
    input  logic [7:0]  i_byte,
    output logic [11:0] o_col,
    output logic        o_bad
);
    logic [3:0] zone;
    logic [3:0] dig;
    logic       dig_ok;

    assign zone   = i_byte[7:4];
    assign dig    = i_byte[3:0];
    assign dig_ok = (dig >= 4'd1) && (dig <= 4'd9);

    always_comb begin
        o_col = HOLL_BLANK;
        o_bad = 1'b0;
        if (i_byte == E_SP) begin
            o_col = HOLL_BLANK;
        end else if (i_byte == E_0) begin
            o_col = row_n(4'd0);
        end else if (zone == E_0[7:4] && dig_ok) begin
            o_col = row_n(dig);
        end else if (zone == E_A[7:4] && dig_ok) begin
            o_col = (12'(1) << ROW12) | row_n(dig);
        end else if (zone == E_J[7:4] && dig_ok) begin
            o_col = (12'(1) << ROW11) | row_n(dig);
        end else if (zone == E_S[7:4] && dig >= E_S[3:0] && dig <= 4'd9) begin
            o_col = (12'(1) << ROW0) | row_n(dig);
        end else if (i_byte == E_PERIOD) begin
            o_col = (12'(1) << ROW12) | (12'(1) << ROW3) | (12'(1) << ROW8);
        end else if (i_byte == E_COMMA) begin
            o_col = (12'(1) << ROW0) | (12'(1) << ROW3) | (12'(1) << ROW8);
        end else if (i_byte == E_MINUS) begin
            o_col = 12'(1) << ROW11;
        end else if (i_byte == E_SLASH) begin
            o_col = (12'(1) << ROW0) | (12'(1) << ROW1);
        end else if (i_byte == E_AMP) begin
            o_col = 12'(1) << ROW12;
        end else begin
            o_bad = 1'b1;
        end
    end
endmodule

// File: rtl/punch_encode1.sv
// rtl/punch_encode1.sv - punch-side encoder: byte stream to padded card column stream
module punch_encode1
    import punch_encode1_pkg::*;
#(
    parameter int CARD_COLS = 80,
    parameter int CW        = 8
) (
    input  logic            clk,
    input  logic            rst,
    punch_encode1_if.slave  bus
);
    localparam logic [CW-1:0] LAST_COL = CW'(CARD_COLS - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, err_q, last_q;
    logic [11:0]   col_q;
    logic [CW-1:0] colno_q;

    logic [11:0]   enc_col;
    logic          enc_bad;
    logic          slot_free, accept, pad_load, load;

    punch_encode1_ebcdic_to_holl u_enc (
        .i_byte (bus.i_byte),
        .o_col  (enc_col),
        .o_bad  (enc_bad)
    );

    assign slot_free   = !valid_q || bus.i_col_ready;
    assign bus.o_ready = (state_q == ST_RUN) && slot_free;
    assign accept      = bus.i_valid && bus.o_ready;
    assign pad_load    = (state_q == ST_PAD) && slot_free;
    assign load        = accept || pad_load;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (cnt_q == LAST_COL) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            col_q   <= HOLL_BLANK;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            colno_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                valid_q <= 1'b1;
                col_q   <= accept ? enc_col : HOLL_BLANK;
                err_q   <= accept && enc_bad;
                last_q  <= (cnt_q == LAST_COL);
                colno_q <= cnt_q;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end
            // Flush looks at the counter after any same-cycle accept so a
            // card completed by that byte needs no padding.
            case (state_q)
                ST_RUN: if (bus.i_flush && cnt_d != '0) state_q <= ST_PAD;
                ST_PAD: if (pad_load && cnt_q == LAST_COL) state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign bus.o_col_valid = valid_q;
    assign bus.o_col       = col_q;
    assign bus.o_err       = err_q;
    assign bus.o_last      = last_q;
    assign bus.o_colno     = colno_q;
endmodule

// File: tb/tb_punch_encode1.sv
// tb/tb_punch_encode1.sv - directed self-checking bench for punch_encode1
module tb_punch_encode1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    punch_encode1_if #(.CW(8)) bus ();

    punch_encode1 #(.CARD_COLS(80), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic fl, input logic [11:0] ecol,
                        input logic eerr, input int ecolno, input logic elast);
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_byte  = b;
        bus.i_flush = fl;
        #1;
        check("push_rdy", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_flush = 1'b0;
        check("col_vld", 32'(bus.o_col_valid), 32'd1);
        check("col", 32'(bus.o_col), 32'(ecol));
        check("err", 32'(bus.o_err), 32'(eerr));
        check("colno", 32'(bus.o_colno), 32'(ecolno));
        check("last", 32'(bus.o_last), 32'(elast));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, "_vld"}, 32'(bus.o_col_valid), 32'd0);
            check({tag, "_rdy"}, 32'(bus.o_ready), 32'd1);
        end
    endtask

    logic [7:0]  vb[12]   = '{8'hC1, 8'hF0, 8'hF9, 8'hD1, 8'hE2, 8'h4B,
                              8'h6B, 8'h60, 8'h61, 8'h50, 8'h40, 8'h41};
    logic [11:0] vcol[12] = '{12'h900, 12'h200, 12'h001, 12'h500, 12'h280, 12'h842,
                              12'h242, 12'h400, 12'h300, 12'h800, 12'h000, 12'h000};

    initial begin
        int npad;
        int expn;
        bit done;
        bus.i_valid     = 1'b0;
        bus.i_byte      = 8'h00;
        bus.i_flush     = 1'b0;
        bus.i_col_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_vld", 32'(bus.o_col_valid), 32'd0);
        check("rst_col", 32'(bus.o_col), 32'd0);
        check("rst_colno", 32'(bus.o_colno), 32'd0);
        check("rst_last", 32'(bus.o_last), 32'd0);
        check("rst_err", 32'(bus.o_err), 32'd0);
        check("rst_rdy", 32'(bus.o_ready), 32'd1);

        // Encoding table, column numbers 0..11, last entry unmapped.
        for (int i = 0; i < 12; i++)
            push(vb[i], 1'b0, vcol[i], (i == 11), i, 1'b0);

        // Backpressure: column 12 held while byte F2 waits.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_byte  = 8'hF1;
        @(negedge clk);
        bus.i_byte      = 8'hF2;
        bus.i_col_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_rdy", 32'(bus.o_ready), 32'd0);
            check("bp_vld", 32'(bus.o_col_valid), 32'd1);
            check("bp_col", 32'(bus.o_col), 32'h100);
            check("bp_colno", 32'(bus.o_colno), 32'd12);
            @(negedge clk);
        end
        bus.i_col_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 32'(bus.o_ready), 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        check("bp_next_col", 32'(bus.o_col), 32'h080);
        check("bp_next_colno", 32'(bus.o_colno), 32'd13);
        @(negedge clk);
        check("bp_drain", 32'(bus.o_col_valid), 32'd0);

        // Three bytes then flush: 77 blank columns to finish the card.
        do_reset();
        push(8'hF1, 1'b0, 12'h100, 1'b0, 0, 1'b0);
        push(8'hF2, 1'b0, 12'h080, 1'b0, 1, 1'b0);
        push(8'hF3, 1'b0, 12'h040, 1'b0, 2, 1'b0);
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        npad = 0;
        expn = 3;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (!(bus.o_col_valid && bus.o_last))
                check("pad_rdy", 32'(bus.o_ready), 32'd0);
            if (bus.o_col_valid) begin
                check("pad_col", 32'(bus.o_col), 32'd0);
                check("pad_err", 32'(bus.o_err), 32'd0);
                check("pad_colno", 32'(bus.o_colno), 32'(expn));
                check("pad_last", 32'(bus.o_last), 32'(expn == 79));
                npad++;
                expn++;
                if (bus.o_last) done = 1;
            end
            if (!done) @(negedge clk);
        end
        check("pad_count", 32'(npad), 32'd77);
        push(8'hF5, 1'b0, 12'h010, 1'b0, 0, 1'b0);

        // Full card with flush on the 80th accept: no padding.
        do_reset();
        for (int i = 0; i < 80; i++)
            push(8'hC1, (i == 79), 12'h900, 1'b0, i, (i == 79));
        idle_check("nopad", 3);
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush0_vld", 32'(bus.o_col_valid), 32'd0);
        idle_check("flush0", 3);

        // Reset while padding.
        do_reset();
        push(8'hF1, 1'b0, 12'h100, 1'b0, 0, 1'b0);
        push(8'hF2, 1'b0, 12'h080, 1'b0, 1, 1'b0);
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        repeat (4) @(negedge clk);
        check("midpad_vld", 32'(bus.o_col_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstpad_vld", 32'(bus.o_col_valid), 32'd0);
        check("rstpad_colno", 32'(bus.o_colno), 32'd0);
        check("rstpad_rdy", 32'(bus.o_ready), 32'd1);
        push(8'hF7, 1'b0, 12'h004, 1'b0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
